// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//   Bit-serial adder controller. One 1-bit full-add cell (two half adders plus
//   an OR for carry-out) is time-shared LSB-first across all WIDTH bit
//   positions. The carry lives in a flip-flop between cycles. A
//   start/busy/done handshake reports completion. One add takes WIDTH+2
//   cycles from accept to the next possible accept.
//
//   Build option: define SERIAL_ADD_SUB_EN to add the 'sub' input. With
//   sub=1 the block computes a - b (two's complement), and cout=1 means
//   no borrow. Leave it undefined for an add-only block.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request a new operation (sampled only in IDLE)
//   sub    in   subtract select, sampled with start (SERIAL_ADD_SUB_EN only)
//   a, b   in   WIDTH-bit operands, captured on the accepting edge
//   busy   out  high in RUN and DONE
//   done   out  one-cycle pulse when sum/cout are valid
//   sum    out  WIDTH-bit result, held until overwritten by the next operation
//   cout   out  final carry-out, held with sum
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; sum/cout hold the previous result
//   RUN   | one bit position added per cycle, LSB first, WIDTH cycles
//   DONE  | done pulse cycle; returns to IDLE on the next edge
// -----------------------------------------------------------------------------
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;

  // Operand B and the initial carry as loaded on accept. Subtraction is
  // a + ~b + 1, so it reuses the adder with an inverted B and carry-in of 1.
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

`ifdef SERIAL_ADD_SUB_EN
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub;
`else
  assign b_load     = b;
  assign carry_load = 1'b0;
`endif

  // Shared 1-bit datapath: two half-adder cells and an OR for carry-out.
  logic ha0_s, ha0_c, ha1_s, ha1_c, fa_c;

  assign ha0_s = a_sh[0] ^ b_sh[0];
  assign ha0_c = a_sh[0] & b_sh[0];
  assign ha1_s = ha0_s ^ carry;
  assign ha1_c = ha0_s & carry;
  assign fa_c  = ha0_c | ha1_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      carry <= 1'b0;
      cnt   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b_load;
            carry <= carry_load;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end

        ST_RUN: begin
          sum   <= {ha1_s, sum[WIDTH-1:1]};
          carry <= fa_c;
          a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
          cnt   <= cnt + 1'b1;
          // The last bit position is being added on this edge.
          if (cnt == LAST) begin
            cout  <= fa_c;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end

        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
//   Self-checking bench for serial_add_ctrl (WIDTH=8). The expected sum and
//   carry come from plain integer arithmetic on the operands. Latency, the
//   busy window and done spacing are checked against cycle counts.
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub;
`endif

  int checks;
  int errors;
  int cyc;

  logic [W-1:0] exp_sum;
  logic         exp_cout;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Reference: integer arithmetic, result modulo 2^W.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                       input logic msub,
                       output logic [W-1:0] ms, output logic mc);
    int total;
    if (msub) begin
      total = int'(ma) - int'(mb);
      mc    = (int'(ma) >= int'(mb));
    end else begin
      total = int'(ma) + int'(mb);
      mc    = (total >= (1 << W));
    end
    ms = W'(total & ((1 << W) - 1));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation, checked end to end. Called from 1 ns after an edge.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic tsub, input string name);
    logic [W-1:0] prev_sum;
    int           lat;
    int           busy_cnt;
    prev_sum = sum;
    model(ta, tb_v, tsub, exp_sum, exp_cout);
    a     = ta;
    b     = tb_v;
`ifdef SERIAL_ADD_SUB_EN
    sub   = tsub;
`endif
    start = 1'b1;
    tick();                                   // E0
    start = 1'b0;
    a     = W'($urandom);                     // must have no effect
    b     = W'($urandom);
`ifdef SERIAL_ADD_SUB_EN
    sub   = 1'($urandom);
`endif
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || sum !== prev_sum) begin
      errors++;
      $display("FAIL %s accept: busy=%b done=%b sum=%h, required busy=1 done=0 sum=%h",
               name, busy, done, sum, prev_sum);
    end
    busy_cnt = 1;
    lat = -1;
    for (int i = 1; i <= 3 * W; i++) begin
      tick();
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat != W) begin
      errors++;
      $display("FAIL %s latency: done after %0d edges, required %0d", name, lat, W);
    end
    checks++;
    if (sum !== exp_sum || cout !== exp_cout) begin
      errors++;
      $display("FAIL %s result: sum=%h cout=%b, required sum=%h cout=%b",
               name, sum, cout, exp_sum, exp_cout);
    end
    tick();                                   // E(W+1)
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || busy_cnt != W + 1) begin
      errors++;
      $display("FAIL %s end: done=%b busy=%b busy_cycles=%0d, required 0 0 %0d",
               name, done, busy, busy_cnt, W + 1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b sum=%h cout=%b, required 0 0 00 0",
               busy, done, sum, cout);
    end
    do_op(8'h00, 8'h00, 1'b0, "zero_add");
  endtask

  task automatic test_directed();
    do_op(8'h5A, 8'h25, 1'b0, "add_5a_25");
    do_op(8'hFF, 8'h01, 1'b0, "add_ff_01");
    do_op(8'h80, 8'h80, 1'b0, "add_80_80");
    repeat (5) tick();
    checks++;
    if (sum !== 8'h00 || cout !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_idle: sum=%h cout=%b busy=%b, required 00 1 0", sum, cout, busy);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++)
      do_op(W'($urandom), W'($urandom), 1'b0, "random_add");
  endtask

  task automatic test_start_ignored();
    int dones;
    int seen;
    dones = 0;
    a = 8'h0F;
    b = 8'h01;
    start = 1'b1;
    tick();                                   // E0
    start = 1'b0;
    tick();                                   // E1
    tick();                                   // E2
    a = 8'hAA;
    b = 8'hAA;
    start = 1'b1;
    tick();                                   // E3
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 3 * W && seen == 0; i++) begin
      tick();
      if (done === 1'b1) begin
        dones++;
        seen = 1;
      end
    end
    start = 1'b1;                             // asserted during DONE
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_done_start: busy=%b, required 0", busy);
    end
    for (int i = 0; i < 2 * W; i++) begin
      tick();
      if (done === 1'b1) dones++;
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL ignore_no_restart: busy=%b, required 0", busy);
      end
    end
    checks++;
    if (dones != 1 || sum !== 8'h10 || cout !== 1'b0) begin
      errors++;
      $display("FAIL ignore_result: dones=%0d sum=%h cout=%b, required 1 10 0",
               dones, sum, cout);
    end
  endtask

  task automatic test_async_reset();
    int dones;
    dones = 0;
    a = 8'hF0;
    b = 8'h0F;
    start = 1'b1;
    tick();                                   // E0
    start = 1'b0;
    repeat (4) tick();                        // E1..E4
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: busy=%b done=%b sum=%h cout=%b, required 0 0 00 0",
               busy, done, sum, cout);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 2 * W; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL reset_discard: activity cycles=%0d, required 0", dones);
    end
    do_op(8'h01, 8'h01, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    int done_cyc[$];
    int acc_cyc[$];
    logic prev_busy;
    logic [W-1:0] ta, tbv;
    ta  = W'($urandom);
    tbv = W'($urandom);
    model(ta, tbv, 1'b0, exp_sum, exp_cout);
    a = ta;
    b = tbv;
    prev_busy = busy;
    start = 1'b1;
    for (int i = 0; i < 10 * (W + 2) && done_cyc.size() < 3; i++) begin
      tick();
      if (busy === 1'b1 && prev_busy === 1'b0) acc_cyc.push_back(cyc);
      prev_busy = busy;
      if (done === 1'b1) begin
        done_cyc.push_back(cyc);
        checks++;
        if (sum !== exp_sum || cout !== exp_cout) begin
          errors++;
          $display("FAIL b2b_result: sum=%h cout=%b, required sum=%h cout=%b",
                   sum, cout, exp_sum, exp_cout);
        end
      end
    end
    start = 1'b0;
    checks++;
    if (done_cyc.size() != 3 || acc_cyc.size() != 3) begin
      errors++;
      $display("FAIL b2b_count: dones=%0d accepts=%0d, required 3 3",
               done_cyc.size(), acc_cyc.size());
    end else begin
      checks++;
      if (done_cyc[1] - done_cyc[0] != W + 2 || done_cyc[2] - done_cyc[1] != W + 2) begin
        errors++;
        $display("FAIL b2b_done_spacing: %0d %0d, required %0d",
                 done_cyc[1] - done_cyc[0], done_cyc[2] - done_cyc[1], W + 2);
      end
      checks++;
      if (acc_cyc[1] - acc_cyc[0] != W + 2 || acc_cyc[2] - acc_cyc[1] != W + 2) begin
        errors++;
        $display("FAIL b2b_accept_spacing: %0d %0d, required %0d",
                 acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1], W + 2);
      end
    end
    repeat (W + 4) tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stop: busy=%b, required 0", busy);
    end
  endtask

`ifdef SERIAL_ADD_SUB_EN
  task automatic test_sub();
    do_op(8'h10, 8'h01, 1'b1, "sub_10_01");
    do_op(8'h01, 8'h02, 1'b1, "sub_01_02");
    do_op(8'h12, 8'h34, 1'b0, "add_12_34");
    for (int n = 0; n < 10; n++)
      do_op(W'($urandom), W'($urandom), 1'($urandom), "random_addsub");
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    test_reset();
    test_directed();
    test_start_ignored();
    test_async_reset();
    test_random();
    test_back_to_back();
`ifdef SERIAL_ADD_SUB_EN
    test_sub();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller that time-shares one 1-bit full-add datapath across all bit positions of a WIDTH-bit operand pair.
- The datapath is two half-adder cells (XOR/AND) plus an OR for carry-out.
- The controller sequences the datapath LSB-first over WIDTH cycles, holds the carry in a flip-flop between cycles, and reports completion through a start/busy/done handshake.
- Used wherever area matters more than add latency.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a new addition; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; sum and cout valid.
- sum  output  WIDTH  result register; holds until the next accepted start.
- cout  output  1  final carry-out; holds with sum.

Behaviour:
- Reset (rst_n low, asynchronous, any state): state=IDLE, busy=0, done=0, sum=0, cout=0, carry FF=0, bit counter=0, shift registers=0. An operation in progress is discarded with no done pulse. Release is synchronous to the next clk edge.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - busy=0, done=0.
  - If start=1 at an edge: load a_sh<=a, b_sh<=b, carry<=0 (carry<=1 when subtracting, see below), cnt<=0, go to RUN. This edge is E0.
  - sum and cout are not cleared on accept; they keep the previous result until overwritten.
- RUN, each edge:
  - s = a_sh[0]^b_sh[0]^carry.
  - carry <= (a_sh[0]&b_sh[0]) | ((a_sh[0]^b_sh[0])&carry).
  - s is shifted into sum at the MSB end (sum <= {s, sum[WIDTH-1:1]}).
  - a_sh and b_sh shift right; cnt increments.
  - On the edge where cnt==WIDTH-1 (edge E(WIDTH)): cout <= final carry, done <= 1, go to DONE.
- DONE:
  - busy=1, done=1 for exactly one cycle.
  - Next edge: done<=0, go to IDLE.
- Latency: start accepted at E0 → done high in the cycle after edge E(WIDTH) → back in IDLE after E(WIDTH+1). Throughput is one add per WIDTH+2 cycles.
- start while busy=1 (RUN or DONE): ignored, with no queuing or effect on the current operation.
- a and b changing after E0: no effect.
- Counter width is $clog2(WIDTH). Count wrap is never reached because the state leaves RUN at WIDTH-1.
- Overflow: the result is modulo 2^WIDTH. cout carries the bit-WIDTH carry.
- Simultaneous rst_n low and start: reset wins.

Optional Feature:
- Macro SERIAL_ADD_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled with start at E0 and held internally for the operation.
  - When sub=1: b_sh loads ~b and the initial carry=1, giving sum = a - b (two's complement). cout=1 means no borrow (a >= b unsigned).
  - When sub=0: behaviour is identical to the undefined case.
  - Latency is unchanged.
- Undefined: the sub port and its logic are absent; the block is add-only.

Test Plan (WIDTH=8):
- Reset, then start with a=0x00, b=0x00 → done pulses in the cycle after E8, sum=0x00, cout=0, busy high for exactly 9 cycles, back to IDLE.
- a=0x5A, b=0x25 → sum=0x7F, cout=0. Then a=0xFF, b=0x01 → sum=0x00, cout=1. Then a=0x80, b=0x80 → sum=0x00, cout=1. Previous sum is held between operations.
- Start with a=0x0F, b=0x01, then pulse start with a=0xAA, b=0xAA at E3 and again in the DONE cycle → both pulses ignored, sum=0x10, cout=0, exactly one done pulse.
- Start with a=0xF0, b=0x0F, assert rst_n low after E4 → busy, done, sum and cout drop to 0 immediately (asynchronously), no done pulse. Release, then start a=0x01, b=0x01 → sum=0x02, cout=0.
- Back-to-back: hold start high continuously → a new accept every 10 cycles (E0 to next E0), done pulses spaced 10 cycles apart.
- SERIAL_ADD_SUB_EN: sub=1, a=0x10, b=0x01 → sum=0x0F, cout=1. sub=1, a=0x01, b=0x02 → sum=0xFF, cout=0. sub=0, a=0x12, b=0x34 → sum=0x46, cout=0.
